// File: rtl/axis_wr_pattern_gen.sv
// AXIS traffic source for the DDR write-bandwidth path: emits nburst bursts of
// seed-derived lane data and counts accepted beats and back-pressure stalls.
module axis_wr_pattern_gen #(
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LENGTH = 7
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [31:0]             nburst,
  input  logic [31:0]             seed,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             beat_cnt,
  output logic [31:0]             stall_cnt
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam int BIB_W = (BURST_LENGTH > 0) ? $clog2(BURST_LENGTH + 1) : 1;
  localparam logic [BIB_W-1:0] BIB_LAST = BIB_W'(BURST_LENGTH);
  localparam logic [39:0] BEATS_PER_BURST = 40'(BURST_LENGTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Even 32-bit lanes carry w, odd lanes carry its complement.
  function automatic logic [DATA_WIDTH-1:0] lane_pattern(input logic [31:0] w);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < LANES; i++) begin
      d[i*32 +: 32] = (i % 2 == 0) ? w : ~w;
    end
    return d;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_e                  state_q;
  logic                    tvalid_q;
  logic [DATA_WIDTH-1:0]   tdata_q;
  logic [DATA_WIDTH/8-1:0] tstrb_q;
  logic                    tlast_q;
  logic                    busy_q;
  logic                    done_q;
  logic [31:0]             seed_q;
  logic [31:0]             beat_cnt_q;
  logic [31:0]             stall_cnt_q;
  logic [BIB_W-1:0]        bib_q;
  logic [39:0]             sent_q;
  logic [39:0]             total_q;

  logic                    hs;
  logic                    last_hs;
  logic [31:0]             beat_cnt_d;
  logic [31:0]             stall_cnt_d;
  logic [BIB_W-1:0]        bib_d;
  logic [39:0]             sent_d;

  always_comb begin
    hs          = tvalid_q & m_axis_tready;
    beat_cnt_d  = beat_cnt_q + 32'd1;
    stall_cnt_d = sat_inc32(stall_cnt_q);
    bib_d       = (bib_q == BIB_LAST) ? '0 : bib_q + 1'b1;
    sent_d      = sent_q + 40'd1;
    // The end test runs on a 40-bit beat count so large nburst never aliases.
    last_hs     = hs && (sent_d == total_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tstrb_q     <= '0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      seed_q      <= '0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
      bib_q       <= '0;
      sent_q      <= '0;
      total_q     <= '0;
    end else begin
      tstrb_q <= '1;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
            bib_q       <= '0;
            sent_q      <= '0;
            if (nburst != 32'd0) begin
              seed_q   <= seed;
              total_q  <= 40'(nburst) * BEATS_PER_BURST;
              tvalid_q <= 1'b1;
              tdata_q  <= lane_pattern(seed);
              tlast_q  <= (BIB_LAST == '0);
              busy_q   <= 1'b1;
              state_q  <= RUN;
            end else begin
              state_q  <= DONE;
            end
          end
        end
        RUN: begin
          if (tvalid_q && !m_axis_tready) begin
            stall_cnt_q <= stall_cnt_d;
          end
          if (hs) begin
            beat_cnt_q <= beat_cnt_d;
            sent_q     <= sent_d;
            bib_q      <= bib_d;
            if (last_hs) begin
              tvalid_q <= 1'b0;
              tdata_q  <= '0;
              tlast_q  <= 1'b0;
              busy_q   <= 1'b0;
              state_q  <= DONE;
            end else begin
              // Next beat's data is indexed by the post-handshake beat count.
              tdata_q  <= lane_pattern(seed_q + beat_cnt_d);
              tlast_q  <= (bib_d == BIB_LAST);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tstrb  = tstrb_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign beat_cnt      = beat_cnt_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_axis_wr_pattern_gen.sv
// Directed and randomized bench for axis_wr_pattern_gen against a beat-stream
// reference model derived from seed, burst count and burst length.
module tb_axis_wr_pattern_gen;

  localparam int DW    = 64;
  localparam int BEATS = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   nburst = '0;
  logic [31:0]   seed = '0;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic [DW/8-1:0] m_axis_tstrb;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic          busy;
  logic          done;
  logic [31:0]   beat_cnt;
  logic [31:0]   stall_cnt;

  axis_wr_pattern_gen #(.DATA_WIDTH(DW), .BURST_LENGTH(BEATS - 1)) dut (
    .clk(clk), .rstn(rstn), .start(start), .nburst(nburst), .seed(seed),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tstrb(m_axis_tstrb), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .busy(busy), .done(done),
    .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Monitor state
  logic [DW-1:0] cap_data[$];
  bit            cap_last[$];
  int            hs_cyc[$];
  int            cyc = 0;
  int            stall_seen = 0;
  int            vld_cycles = 0;
  int            done_seen = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  // Ready driver: 0 always high, 1 toggle, 2 random, 3 low for hold_left valid cycles
  int rmode = 0;
  int hold_left = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_data(input logic [31:0] s, input int k);
    logic [31:0] w;
    w = s + 32'(k);
    return {~w, w};
  endfunction

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ~m_axis_tready;
      2: m_axis_tready = 1'($urandom_range(0, 1));
      default: begin
        if (hold_left > 0) begin
          m_axis_tready = 1'b0;
          if (m_axis_tvalid) hold_left--;
        end else begin
          m_axis_tready = 1'b1;
        end
      end
    endcase
  end

  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 0;
    end else begin
      cyc++;
      if (prev_stall) begin
        chk("axis_hold_valid", 64'(m_axis_tvalid), 64'd1);
        chk("axis_hold_data", m_axis_tdata, prev_data);
        chk("axis_hold_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (m_axis_tvalid) begin
        vld_cycles++;
        if (m_axis_tready) begin
          cap_data.push_back(m_axis_tdata);
          cap_last.push_back(m_axis_tlast);
          hs_cyc.push_back(cyc);
        end else begin
          stall_seen++;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (done) done_seen++;
    end
  end

  task automatic clear_mon();
    cap_data.delete();
    cap_last.delete();
    hs_cyc.delete();
    stall_seen = 0;
    vld_cycles = 0;
    done_seen  = 0;
  endtask

  task automatic do_start(input logic [31:0] n, input logic [31:0] s);
    @(posedge clk); #1;
    start = 1'b1; nburst = n; seed = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (done_seen == 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_done_timeout"}, 64'(done_seen != 0), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int i;
    i = 0;
    while (cap_data.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_beat_timeout"}, 64'(cap_data.size() >= n), 64'd1);
  endtask

  task automatic run_check(input string tag, input logic [31:0] s, input int n);
    int nb;
    nb = n * BEATS;
    chk({tag, "_nbeats"}, 64'(cap_data.size()), 64'(nb));
    for (int k = 0; k < nb && k < cap_data.size(); k++) begin
      chk($sformatf("%s_data%0d", tag, k), cap_data[k], ref_data(s, k));
      chk($sformatf("%s_last%0d", tag, k), 64'(cap_last[k]), 64'((k % BEATS) == BEATS - 1));
    end
    chk({tag, "_beat_cnt"}, 64'(beat_cnt), 64'(nb));
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(stall_seen));
    chk({tag, "_done_once"}, 64'(done_seen), 64'd1);
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    chk({tag, "_valid_low"}, 64'(m_axis_tvalid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] s;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tstrb", 64'(m_axis_tstrb), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    #2 rstn = 1'b1;

    // Two bursts back to back with ready held high
    rmode = 0;
    clear_mon();
    do_start(32'd2, 32'd0);
    @(negedge clk);
    chk("t1_latency_valid", 64'(m_axis_tvalid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_tstrb", 64'(m_axis_tstrb), 64'hFF);
    wait_done("t1", 100);
    run_check("t1", 32'd0, 2);
    if (cap_data.size() == 16) begin
      chk("t1_beat0", cap_data[0], 64'hFFFFFFFF_00000000);
      chk("t1_beat15", cap_data[15], 64'hFFFFFFF0_0000000F);
      chk("t1_consecutive", 64'(hs_cyc[15] - hs_cyc[0]), 64'd15);
    end
    chk("t1_stall_zero", 64'(stall_cnt), 64'd0);

    // Toggling ready with a seed that wraps within the burst
    rmode = 1;
    clear_mon();
    do_start(32'd1, 32'hFFFF_FFFE);
    wait_done("t2", 100);
    run_check("t2", 32'hFFFF_FFFE, 1);
    if (cap_data.size() == 8) begin
      chk("t2_lane0_b1", 64'(cap_data[1][31:0]), 64'hFFFF_FFFF);
      chk("t2_lane0_b2", 64'(cap_data[2][31:0]), 64'h0);
      chk("t2_lane0_b3", 64'(cap_data[3][31:0]), 64'h1);
    end

    // Zero bursts: no beats, done two cycles after start, counters cleared
    rmode = 0;
    clear_mon();
    do_start(32'd0, 32'h1234_5678);
    @(negedge clk);
    chk("t3_done_c1", 64'(done), 64'd0);
    @(negedge clk);
    chk("t3_done_c2", 64'(done), 64'd1);
    chk("t3_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("t3_stall_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    chk("t3_done_c3", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("t3_no_valid", 64'(vld_cycles), 64'd0);
    chk("t3_done_once", 64'(done_seen), 64'd1);

    // Start during RUN is ignored and not queued
    s = $urandom;
    clear_mon();
    do_start(32'd1, s);
    wait_beats("t4", 3, 50);
    @(posedge clk); #1;
    start = 1'b1; nburst = 32'd5; seed = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t4", 100);
    run_check("t4", s, 1);
    repeat (6) @(negedge clk);
    chk("t4_no_restart", 64'(vld_cycles), 64'd8);
    chk("t4_single_done", 64'(done_seen), 64'd1);

    // Reset mid-run aborts immediately; a fresh run restarts from idx 0
    clear_mon();
    do_start(32'd4, $urandom);
    wait_beats("t5", 5, 50);
    #2 rstn = 1'b0;
    #1;
    chk("t5_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t5_rst_tdata", m_axis_tdata, 64'd0);
    chk("t5_rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_beat_cnt", 64'(beat_cnt), 64'd0);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("t5_idle_after_rst", 64'(m_axis_tvalid), 64'd0);
    chk("t5_no_done", 64'(done_seen), 64'd0);
    s = $urandom;
    clear_mon();
    do_start(32'd1, s);
    wait_done("t5", 100);
    run_check("t5", s, 1);

    // Long stall on the first beat
    s = $urandom;
    hold_left = 100;
    rmode = 3;
    clear_mon();
    do_start(32'd1, s);
    wait_done("t6", 300);
    run_check("t6", s, 1);
    chk("t6_stall_100", 64'(stall_cnt), 64'd100);
    if (cap_data.size() > 0) chk("t6_first_beat", cap_data[0], ref_data(s, 0));

    // Randomized runs with random back-pressure
    rmode = 2;
    for (int it = 0; it < 3; it++) begin
      s = $urandom;
      n = $urandom_range(1, 3);
      clear_mon();
      do_start(32'(n), s);
      wait_done($sformatf("rnd%0d", it), 400);
      run_check($sformatf("rnd%0d", it), s, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
